// File: rtl/ram_bank_arbiter.sv
// ram_bank_arbiter: round-robin sharing of one single-port RAM bank between two requesters
module ram_bank_arbiter #(
    parameter int ADDR_BIT = 3,
    parameter int DATA_BIT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_a,
    input  logic                req_b,
    input  logic                we_a,
    input  logic                we_b,
    input  logic [ADDR_BIT-1:0] addr_a,
    input  logic [ADDR_BIT-1:0] addr_b,
    input  logic [DATA_BIT-1:0] wdata_a,
    input  logic [DATA_BIT-1:0] wdata_b,
    output logic                gnt_a,
    output logic                gnt_b,
    output logic                rvalid_a,
    output logic                rvalid_b,
    output logic [DATA_BIT-1:0] rdata,
    output logic                ram_en,
    output logic                ram_we,
    output logic                ram_re,
    output logic [ADDR_BIT-1:0] ram_addr_w,
    output logic [ADDR_BIT-1:0] ram_addr_r,
    output logic [DATA_BIT-1:0] ram_d_w,
    input  logic [DATA_BIT-1:0] ram_d_r
);
    logic last_gnt;
    logic rv_a, rv_b;
    logic any_gnt, sel_we;
    logic [ADDR_BIT-1:0] sel_addr;
    always_comb begin
        gnt_a      = !rst && req_a && (!req_b || last_gnt);
        gnt_b      = !rst && req_b && (!req_a || !last_gnt);
        any_gnt    = gnt_a || gnt_b;
        sel_we     = gnt_b ? we_b : we_a;
        sel_addr   = !any_gnt ? '0 : gnt_b ? addr_b : addr_a;
        ram_en     = any_gnt;
        ram_we     = any_gnt && sel_we;
        ram_re     = any_gnt && !sel_we;
        ram_addr_w = sel_addr;
        ram_addr_r = sel_addr;
        ram_d_w    = !any_gnt ? '0 : gnt_b ? wdata_b : wdata_a;
        // a read granted just before reset is dropped while reset is held
        rvalid_a   = rv_a && !rst;
        rvalid_b   = rv_b && !rst;
        rdata      = ram_d_r;
    end
    // last_gnt: 1 means B was granted most recently, so A wins the next contention
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt <= 1'b1;
            rv_a     <= 1'b0;
            rv_b     <= 1'b0;
        end else begin
            if (any_gnt) last_gnt <= gnt_b;
            rv_a <= gnt_a && !we_a;
            rv_b <= gnt_b && !we_b;
        end
    end
endmodule

// File: tb/tb_ram_bank_arbiter.sv
// tb_ram_bank_arbiter: scenario tasks with a read scoreboard against an external RAM model
module tb_ram_bank_arbiter;
    localparam int AW = 3;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_a = 1'b0, req_b = 1'b0, we_a = 1'b0, we_b = 1'b0;
    logic [AW-1:0] addr_a = '0, addr_b = '0;
    logic [DW-1:0] wdata_a = '0, wdata_b = '0;
    logic          gnt_a, gnt_b, rvalid_a, rvalid_b;
    logic [DW-1:0] rdata;
    logic          ram_en, ram_we, ram_re;
    logic [AW-1:0] ram_addr_w, ram_addr_r;
    logic [DW-1:0] ram_d_w;
    logic [DW-1:0] ram_d_r = '0;

    always #5 clk = ~clk;

    ram_bank_arbiter #(.ADDR_BIT(AW), .DATA_BIT(DW)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
        .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
        .rdata(rdata), .ram_en(ram_en), .ram_we(ram_we), .ram_re(ram_re),
        .ram_addr_w(ram_addr_w), .ram_addr_r(ram_addr_r), .ram_d_w(ram_d_w),
        .ram_d_r(ram_d_r)
    );

    // external bank with registered read data
    logic [DW-1:0] ram [8] = '{16'h5a5a, 16'h1111, 16'h2222, 16'h3333,
                               16'h4444, 16'h5555, 16'h6666, 16'h7777};
    always @(posedge clk) begin
        if (ram_en && ram_we) ram[ram_addr_w] <= ram_d_w;
        if (ram_en && ram_re) ram_d_r <= ram[ram_addr_r];
    end

    typedef struct packed { logic own; logic [DW-1:0] d; } rd_t;
    logic [DW-1:0] ref_mem [8] = '{16'h5a5a, 16'h1111, 16'h2222, 16'h3333,
                                   16'h4444, 16'h5555, 16'h6666, 16'h7777};
    rd_t  sbq[$];
    rd_t  cur;
    logic cur_v  = 1'b0;
    logic m_last = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic logic eg_a();
        return !rst && req_a && (!req_b || m_last);
    endfunction
    function automatic logic eg_b();
        return !rst && req_b && (!req_a || !m_last);
    endfunction

    // one clock: advance the reference model, queue granted reads, expose the one due now
    task automatic adv();
        logic ga, gb, w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        ga = eg_a();
        gb = eg_b();
        w  = gb ? we_b : we_a;
        a  = gb ? addr_b : addr_a;
        d  = gb ? wdata_b : wdata_a;
        @(posedge clk);
        if (rst) begin
            m_last = 1'b1;
            sbq.delete();
        end else if (ga || gb) begin
            m_last = gb;
            if (w) ref_mem[a] = d;
            else sbq.push_back('{own: gb, d: ref_mem[a]});
        end
        cur_v = 1'b0;
        if (sbq.size() > 0) begin
            cur   = sbq.pop_front();
            cur_v = 1'b1;
        end
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_a = 1'b1; req_b = 1'b1; we_a = 1'b0; we_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++;
            if ({gnt_a, gnt_b, ram_en, ram_we, ram_re, rvalid_a, rvalid_b} !== 7'b0) begin
                n_fail++;
                $display("FAIL reset_outputs cyc%0d got gnt=%b%b en/we/re=%b%b%b rv=%b%b required all 0",
                         i, gnt_a, gnt_b, ram_en, ram_we, ram_re, rvalid_a, rvalid_b);
            end
            adv();
        end
        rst = 1'b0; req_a = 1'b0; req_b = 1'b0;
    endtask

    task automatic test_write_read();
        req_a = 1'b1; we_a = 1'b1; addr_a = 3'd3; wdata_a = 16'h1234;
        #1;
        n_chk++;
        if ({gnt_a, gnt_b, ram_en, ram_we, ram_re} !== 5'b10110 || ram_addr_w !== 3'd3 || ram_d_w !== 16'h1234) begin
            n_fail++;
            $display("FAIL wr_drive got gnt=%b%b en/we/re=%b%b%b addr=%0d d=%h required gnt=10 en/we/re=110 addr=3 d=1234",
                     gnt_a, gnt_b, ram_en, ram_we, ram_re, ram_addr_w, ram_d_w);
        end
        adv();
        req_a = 1'b0; req_b = 1'b1; we_b = 1'b0; addr_b = 3'd3;
        #1;
        n_chk++;
        if ({gnt_a, gnt_b, ram_re, ram_we, rvalid_a, rvalid_b} !== 6'b011000 || ram_addr_r !== 3'd3) begin
            n_fail++;
            $display("FAIL rd_drive got gnt=%b%b re/we=%b%b rv=%b%b addr=%0d required gnt=01 re/we=10 rv=00 addr=3",
                     gnt_a, gnt_b, ram_re, ram_we, rvalid_a, rvalid_b, ram_addr_r);
        end
        adv();
        req_b = 1'b0;
        #1;
        n_chk++;
        if ({rvalid_a, rvalid_b} !== 2'b01 || rdata !== 16'h1234 || !(cur_v && cur.own && cur.d === 16'h1234)) begin
            n_fail++;
            $display("FAIL wr_rd_data got rv=%b%b rdata=%h required rv=01 rdata=1234", rvalid_a, rvalid_b, rdata);
        end
        n_chk++;
        if ({ram_en, ram_we, ram_re} !== 3'b0 || ram_addr_w !== '0 || ram_addr_r !== '0 || ram_d_w !== '0) begin
            n_fail++;
            $display("FAIL idle_drive got en/we/re=%b%b%b aw=%0d ar=%0d d=%h required all 0",
                     ram_en, ram_we, ram_re, ram_addr_w, ram_addr_r, ram_d_w);
        end
        adv();
    endtask

    task automatic test_fair();
        rst = 1'b1;
        adv();
        rst = 1'b0;
        req_a = 1'b1; req_b = 1'b1; we_a = 1'b0; we_b = 1'b0; addr_a = 3'd1; addr_b = 3'd2;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin req_a = 1'b0; req_b = 1'b0; end
            #1;
            n_chk++;
            if ({gnt_a, gnt_b} !== (i == 4 ? 2'b00 : i % 2 == 0 ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL fair_gnt cyc%0d got %b%b required %b", i, gnt_a, gnt_b,
                         (i == 4 ? 2'b00 : i % 2 == 0 ? 2'b10 : 2'b01));
            end
            n_chk++;
            if ({rvalid_a, rvalid_b} !== (i == 0 ? 2'b00 : i % 2 == 1 ? 2'b10 : 2'b01) ||
                (i > 0 && rdata !== (i % 2 == 1 ? ref_mem[1] : ref_mem[2]))) begin
                n_fail++;
                $display("FAIL fair_rvalid cyc%0d got rv=%b%b rdata=%h required owner %s data %h", i,
                         rvalid_a, rvalid_b, rdata, i == 0 ? "none" : i % 2 == 1 ? "A" : "B",
                         i % 2 == 1 ? ref_mem[1] : ref_mem[2]);
            end
            adv();
        end
    endtask

    task automatic test_single_stream();
        we_a = 1'b0;
        for (int i = 0; i < 6; i++) begin
            req_a = i < 5; addr_a = AW'(i + 2);
            #1;
            n_chk++;
            if (gnt_a !== (i < 5) || gnt_b !== 1'b0) begin
                n_fail++;
                $display("FAIL stream_gnt cyc%0d got %b%b required %b0", i, gnt_a, gnt_b, i < 5);
            end
            n_chk++;
            if (rvalid_a !== (i >= 1) || rvalid_b !== 1'b0 || (cur_v && rdata !== cur.d) ||
                cur_v !== (i >= 1)) begin
                n_fail++;
                $display("FAIL stream_rvalid cyc%0d got rv=%b%b rdata=%h required rv=%b0 data %h",
                         i, rvalid_a, rvalid_b, rdata, i >= 1, cur.d);
            end
            adv();
        end
    endtask

    task automatic test_reset_suppress();
        req_a = 1'b1; we_a = 1'b0; addr_a = 3'd5;
        #1;
        n_chk++;
        if (gnt_a !== 1'b1) begin
            n_fail++;
            $display("FAIL sup_gnt got %b required 1", gnt_a);
        end
        adv();
        req_a = 1'b0; rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_chk++;
            if ({rvalid_a, rvalid_b, gnt_a, ram_en} !== 4'b0) begin
                n_fail++;
                $display("FAIL sup_rvalid cyc%0d got rv=%b%b gnt_a=%b en=%b required 0",
                         i, rvalid_a, rvalid_b, gnt_a, ram_en);
            end
            adv();
        end
        rst = 1'b0; req_a = 1'b1; req_b = 1'b1; we_b = 1'b0; addr_b = 3'd6;
        #1;
        n_chk++;
        if ({gnt_a, gnt_b, rvalid_a} !== 3'b100) begin
            n_fail++;
            $display("FAIL sup_first_contention got gnt=%b%b rv_a=%b required gnt=10 rv_a=0", gnt_a, gnt_b, rvalid_a);
        end
        adv();
        req_a = 1'b0; req_b = 1'b0;
        #1;
        n_chk++;
        if ({rvalid_a, rvalid_b} !== 2'b10 || rdata !== 16'h5555 || !(cur_v && !cur.own)) begin
            n_fail++;
            $display("FAIL sup_after_read got rv=%b%b rdata=%h required rv=10 rdata=5555", rvalid_a, rvalid_b, rdata);
        end
        adv();
    endtask

    task automatic test_idle();
        req_a = 1'b1; req_b = 1'b1; we_a = 1'b0; we_b = 1'b0; addr_a = 3'd0; addr_b = 3'd7;
        #1;
        n_chk++;
        if ({gnt_a, gnt_b} !== {eg_a(), eg_b()} || {gnt_a, gnt_b} !== 2'b01) begin
            n_fail++;
            $display("FAIL idle_pre_gnt got %b%b required 01", gnt_a, gnt_b);
        end
        adv();
        req_b = 1'b0; req_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++;
            if ({gnt_a, gnt_b, ram_en, ram_we, ram_re} !== 5'b0 ||
                {rvalid_a, rvalid_b} !== {cur_v && !cur.own, cur_v && cur.own} || (cur_v && rdata !== cur.d)) begin
                n_fail++;
                $display("FAIL idle_cyc%0d got gnt=%b%b en=%b rv=%b%b rdata=%h required gnt=00 en=0 rv=%b%b data %h",
                         i, gnt_a, gnt_b, ram_en, rvalid_a, rvalid_b, rdata,
                         cur_v && !cur.own, cur_v && cur.own, cur.d);
            end
            adv();
        end
        req_a = 1'b1; req_b = 1'b1;
        #1;
        n_chk++;
        if ({gnt_a, gnt_b} !== 2'b10 || ram_addr_r !== 3'd0) begin
            n_fail++;
            $display("FAIL idle_post_gnt got %b%b addr=%0d required 10 addr=0", gnt_a, gnt_b, ram_addr_r);
        end
        adv();
        req_a = 1'b0; req_b = 1'b0;
        #1;
        n_chk++;
        if ({rvalid_a, rvalid_b} !== 2'b10 || rdata !== 16'h5a5a) begin
            n_fail++;
            $display("FAIL idle_post_read got rv=%b%b rdata=%h required rv=10 rdata=5a5a", rvalid_a, rvalid_b, rdata);
        end
        adv();
    endtask

    initial begin
        @(posedge clk);
        #2;
        test_reset();
        test_write_read();
        test_fair();
        test_single_stream();
        test_reset_suppress();
        test_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_bank_arbiter.md
RAM_BANK_ARBITER -- requirements
Module: ram_bank_arbiter

Interface
REQ-001 Parameter ADDR_BIT, default 3, address width of the shared bank.
REQ-002 Parameter DATA_BIT, default 16, data width of the shared bank.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req_a, req_b  input  1  each requester's transaction request; held with payload until granted.
REQ-006 we_a, we_b  input  1  transaction type, 1=write, 0=read.
REQ-007 addr_a, addr_b  input  ADDR_BIT  transaction address.
REQ-008 wdata_a, wdata_b  input  DATA_BIT  write data.
REQ-009 gnt_a, gnt_b  output  1  transaction accepted at the coming clk edge.
REQ-010 rvalid_a, rvalid_b  output  1  read data valid for that requester.
REQ-011 rdata  output  DATA_BIT  read data, shared by both requesters, qualified by rvalid_a/rvalid_b.
REQ-012 ram_en, ram_we, ram_re  output  1  bank enable, write enable, read enable.
REQ-013 ram_addr_w, ram_addr_r  output  ADDR_BIT  bank write and read addresses.
REQ-014 ram_d_w  output  DATA_BIT  bank write data.
REQ-015 ram_d_r  input  DATA_BIT  bank registered read data, updated on the edge where en&re=1.

Function
REQ-016 Single-port sharing: at most one of gnt_a/gnt_b high in any cycle.
REQ-017 gnt_x is combinational from req_a, req_b and the registered priority pointer; a transaction completes at the edge where req_x&gnt_x=1.
REQ-018 Only one requesting: that requester granted in the same cycle, no bubble.
REQ-019 Both requesting: requester not granted most recently wins (round-robin); last_gnt register updates only on a granted edge.
REQ-020 No request: gnt_a=gnt_b=0, ram_en=ram_we=ram_re=0, last_gnt held.
REQ-021 Bank drive while granted: ram_en=1, ram_we=we_x, ram_re=~we_x, ram_addr_w=ram_addr_r=addr_x, ram_d_w=wdata_x of the winner.
REQ-022 Bank drive while idle: address and data outputs are 0.
REQ-023 Read latency: rvalid_x=1 for exactly one cycle, the cycle after the granted read edge; rdata=ram_d_r during that cycle.
REQ-024 Writes produce no rvalid.
REQ-025 Back-to-back reads, alternating or repeated requesters, sustain one read per cycle; rvalid owner tag is pipelined per transaction and never mislabelled.
REQ-026 Write then read of the same address on consecutive grants returns the new data.
REQ-027 Requester dropping req without grant: no side effects; last_gnt unchanged.
REQ-028 Fairness: with both requesters continuously requesting, grants strictly alternate A,B,A,B; neither waits more than one cycle.
REQ-029 rdata outside rvalid cycles is don't-care; bench shall not check it.

Reset
REQ-030 While rst=1: gnt_a=gnt_b=0, ram_en=ram_we=ram_re=0, regardless of requests.
REQ-031 On a rst edge: rvalid_a=rvalid_b=0 next cycle; last_gnt set to B, so A wins the first contention.
REQ-032 Reset asserted the cycle after a granted read: that read's rvalid is suppressed.
REQ-033 Bank contents are not cleared by reset.

Verification
REQ-034 Write A addr 3 data 0x1234, then read B addr 3 -> gnt_b next cycle; rvalid_b=1 with rdata=0x1234 one cycle later; rvalid_a stays 0.
REQ-035 Reset release, both req reads (A addr 1, B addr 2) held 4 cycles -> grants A,B,A,B; rvalid owners alternate A,B,A,B; each rdata matches the addressed word.
REQ-036 Only A requests 5 consecutive reads -> gnt_a=1 every cycle; 5 consecutive rvalid_a pulses starting one cycle after the first grant.
REQ-037 Granted read A, rst=1 on the next cycle -> rvalid_a=0 throughout; after release, first contention grants A.
REQ-038 rst=1 with req_a=req_b=1 -> gnt_a=gnt_b=0 and ram_en=0 for every reset cycle.
REQ-039 Idle cycles between requests (req low 3 cycles) -> ram_en=0, last_gnt held; next contention grants the non-last requester.
